dma_transfer_counter: RTL and testbench

Loadable down-counting transfer-length engine for the DMA module. Software or the DMA controller loads a transfer count. The block then grants one transfer per peripheral request using a four-phase `dreq`/`dack` handshake, and decrements the remaining count on each transfer. When the count reaches zero it signals terminal count. It consumes the character counts produced on the protocol side, counting transfers down to zero where the protocol side counts characters up.

---
 rtl/dma_transfer_counter.sv | 119 +++++++++++
 tb/tb_dma_transfer_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_counter.sv
// Down-counting DMA transfer-length engine: grants one dack per dreq/dack
// handshake, counts the loaded length down to zero and pulses tc at the end.
module dma_transfer_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] length,
  input  logic             abort,
  input  logic             dreq,
  output logic             dack,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             tc,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REL = 3'd1,
    WAIT_REQ = 3'd2,
    ACK      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             aborted_q, aborted_d;

  // State, count and abort-confirmation registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= {WIDTH{1'b0}};
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state and count update; abort outranks every other transition
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    aborted_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (load) begin
          if (length != {WIDTH{1'b0}}) begin
            remaining_d = length;
            state_d     = WAIT_REL;
          end else begin
            remaining_d = {WIDTH{1'b0}};
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      // A request still high from the previous transfer must fall first
      WAIT_REL: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!dreq) begin
          state_d = WAIT_REQ;
        end else begin
          state_d = WAIT_REL;
        end
      end
      WAIT_REQ: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (dreq) begin
          state_d = ACK;
        end else begin
          state_d = WAIT_REQ;
        end
      end
      ACK: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          if (remaining_q != {WIDTH{1'b0}}) begin
            remaining_d = remaining_q - {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            remaining_d = {WIDTH{1'b0}};
          end
          if (remaining_q <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = {WIDTH{1'b0}};
      end
    endcase
  end

  assign dack      = (state_q == ACK);
  assign busy      = (state_q == WAIT_REL) || (state_q == WAIT_REQ) || (state_q == ACK);
  assign tc        = (state_q == DONE);
  assign aborted   = aborted_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_dma_transfer_counter.sv
// Directed self-checking bench for dma_transfer_counter (WIDTH=6).
module tb_dma_transfer_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [5:0] length;
  logic       abort;
  logic       dreq;
  logic       dack;
  logic [5:0] remaining;
  logic       busy;
  logic       tc;
  logic       aborted;

  int checks = 0;
  int errors = 0;
  int dack_cnt = 0;
  int dack_base;

  dma_transfer_counter #(.WIDTH(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .length    (length),
    .abort     (abort),
    .dreq      (dreq),
    .dack      (dack),
    .remaining (remaining),
    .busy      (busy),
    .tc        (tc),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dack === 1'b1) dack_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic d, input logic [5:0] r,
                            input logic b, input logic t, input logic a);
    check_val({tag, ".dack"}, {31'd0, dack}, {31'd0, d});
    check_val({tag, ".remaining"}, {26'd0, remaining}, {26'd0, r});
    check_val({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check_val({tag, ".tc"}, {31'd0, tc}, {31'd0, t});
    check_val({tag, ".aborted"}, {31'd0, aborted}, {31'd0, a});
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    length = 6'd0;
    abort  = 1'b0;
    dreq   = 1'b0;
    #2;
    check_outs("reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    #10;
    reset = 1'b0;
    step();
    check_outs("idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Normal 3-transfer block
    dack_base = dack_cnt;
    load = 1'b1; length = 6'd3;
    step();
    check_outs("n3.waitrel", 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check_outs("n3.waitreq", 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) begin
      dreq = 1'b1;
      step();
      check_outs("n3.ack", 1'b1, 6'(i), 1'b1, 1'b0, 1'b0);
      dreq = 1'b0;
      step();
      if (i > 1) begin
        check_outs("n3.after_ack", 1'b0, 6'(i - 1), 1'b1, 1'b0, 1'b0);
        step();
      end
    end
    check_outs("n3.done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("n3.idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_val("n3.dack_count", dack_cnt - dack_base, 32'd3);

    // Zero length
    dack_base = dack_cnt;
    load = 1'b1; length = 6'd0;
    step();
    check_outs("zero.done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    step();
    check_outs("zero.idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_val("zero.dack_count", dack_cnt - dack_base, 32'd0);

    // Stale request across load, then held request after dack
    dack_base = dack_cnt;
    dreq = 1'b1; load = 1'b1; length = 6'd2;
    step();
    load = 1'b0;
    repeat (3) step();
    check_outs("stale.hold", 1'b0, 6'd2, 1'b1, 1'b0, 1'b0);
    check_val("stale.no_dack", dack_cnt - dack_base, 32'd0);
    dreq = 1'b0;
    step();
    dreq = 1'b1;
    step();
    check_outs("stale.ack1", 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
    repeat (4) step();
    check_outs("held.wait", 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
    check_val("held.dack_count", dack_cnt - dack_base, 32'd1);
    dreq = 1'b0;
    step();
    dreq = 1'b1;
    step();
    check_outs("held.ack2", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
    dreq = 1'b0;
    step();
    check_outs("held.done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    step();

    // Abort during the second ACK of a 5-transfer block
    load = 1'b1; length = 6'd5;
    step();
    load = 1'b0;
    step();
    dreq = 1'b1;
    step();
    dreq = 1'b0;
    step();
    check_val("abt.rem_after1", {26'd0, remaining}, 32'd4);
    step();
    dreq = 1'b1;
    step();
    check_outs("abt.ack2", 1'b1, 6'd4, 1'b1, 1'b0, 1'b0);
    abort = 1'b1; dreq = 1'b0;
    step();
    check_outs("abt.pulse", 1'b0, 6'd4, 1'b0, 1'b0, 1'b1);
    abort = 1'b0;
    step();
    check_outs("abt.idle", 1'b0, 6'd4, 1'b0, 1'b0, 1'b0);

    // Load while busy is ignored
    load = 1'b1; length = 6'd7;
    step();
    check_outs("lb.start", 1'b0, 6'd7, 1'b1, 1'b0, 1'b0);
    length = 6'd2;
    step();
    check_outs("lb.ignored", 1'b0, 6'd7, 1'b1, 1'b0, 1'b0);
    load = 1'b0; abort = 1'b1;
    step();
    check_outs("lb.abort", 1'b0, 6'd7, 1'b0, 1'b0, 1'b1);

    // Load and abort together in IDLE: load dropped, no aborted pulse
    load = 1'b1; length = 6'd9;
    step();
    check_outs("la.idle", 1'b0, 6'd7, 1'b0, 1'b0, 1'b0);
    load = 1'b0; abort = 1'b0;
    step();
    check_outs("la.still_idle", 1'b0, 6'd7, 1'b0, 1'b0, 1'b0);

    // Maximum length 63
    dack_base = dack_cnt;
    load = 1'b1; length = 6'd63;
    step();
    load = 1'b0;
    step();
    for (int i = 63; i >= 1; i--) begin
      dreq = 1'b1;
      step();
      check_val("max.dack", {31'd0, dack}, 32'd1);
      check_val("max.rem", {26'd0, remaining}, 32'(i));
      dreq = 1'b0;
      step();
      if (i > 1) step();
    end
    check_outs("max.done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("max.idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_val("max.dack_count", dack_cnt - dack_base, 32'd63);

    // Asynchronous reset mid-block, during an ACK cycle
    load = 1'b1; length = 6'd4;
    step();
    load = 1'b0;
    step();
    dreq = 1'b1;
    step();
    check_val("ar.in_ack", {31'd0, dack}, 32'd1);
    dreq = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outs("ar.async", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outs("ar.after", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
